ssd_scan_driver: RTL and testbench

SSD_SCAN_DRIVER -- requirements
Module: ssd_scan_driver

---
 rtl/ssd_scan_driver.sv | 153 +++++++++++++++
 tb/tb_ssd_scan_driver.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_driver.sv
// Multiplexed seven-segment scan driver: double-buffered digit data, hex font,
// leading-zero suppression, per-slot PWM dimming and registered outputs.
module ssd_scan_driver #(
  parameter int N_DIGITS    = 8,
  parameter int SLOT_CYCLES = 100000,
  parameter int PWM_BITS    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank_in,
  input  logic                  lz_en,
  input  logic                  load,
  input  logic [PWM_BITS-1:0]   brightness,
  input  logic                  display_en,
  output logic [7:0]            ssd_cathodes,
  output logic [7:0]            anodes,
  output logic [2:0]            scan_idx,
  output logic                  frame_tick
);

  localparam int                SLOT_W    = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CYCLES - 1);
  localparam logic [2:0]        IDX_LAST  = 3'(N_DIGITS - 1);

  typedef struct packed {
    logic [4*N_DIGITS-1:0] digits;
    logic [N_DIGITS-1:0]   dp;
    logic [N_DIGITS-1:0]   blank;
    logic                  lz_en;
  } disp_t;

  // Reset image is fully blanked so the display comes up dark.
  localparam disp_t DISP_RESET = {{(4*N_DIGITS){1'b0}}, {N_DIGITS{1'b0}},
                                  {N_DIGITS{1'b1}}, 1'b0};

  function automatic logic [7:0] font(input logic [3:0] v);
    case (v)
      4'h0: font = 8'h03;  4'h1: font = 8'h9F;  4'h2: font = 8'h25;  4'h3: font = 8'h0D;
      4'h4: font = 8'h99;  4'h5: font = 8'h49;  4'h6: font = 8'h41;  4'h7: font = 8'h1F;
      4'h8: font = 8'h01;  4'h9: font = 8'h09;  4'hA: font = 8'h11;  4'hB: font = 8'hC1;
      4'hC: font = 8'h63;  4'hD: font = 8'h85;  4'hE: font = 8'h61;  default: font = 8'h71;
    endcase
  endfunction

  logic [SLOT_W-1:0]   r_slot_cnt;
  logic [2:0]          r_digit_idx;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic                r_pend_valid;
  disp_t               r_pending;
  disp_t               r_active;
  logic [7:0]          r_cathodes;
  logic [7:0]          r_anodes;
  logic [2:0]          r_scan_idx;
  logic                r_frame_tick;

  logic                w_slot_wrap;
  logic                w_frame_wrap;
  logic                w_on;
  disp_t               w_load_data;
  logic [N_DIGITS-1:0] w_suppress;
  logic [3:0]          w_nibble;
  logic                w_dp_cur;
  logic                w_blank_cur;
  logic [7:0]          w_font;
  logic [7:0]          w_cathodes;
  logic [7:0]          w_anodes;

  assign w_slot_wrap  = (r_slot_cnt == SLOT_LAST);
  assign w_frame_wrap = w_slot_wrap && (r_digit_idx == IDX_LAST);
  assign w_load_data  = {digits_in, dp_in, blank_in, lz_en};

  // Zeros are suppressed from the top digit down until the first nonzero one.
  always_comb begin
    logic v_zero_above;
    w_suppress   = '0;
    v_zero_above = r_active.lz_en;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      v_zero_above  = v_zero_above && (r_active.digits[4*i +: 4] == 4'h0);
      w_suppress[i] = v_zero_above;
    end
  end

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_nibble    = 4'h0;
    w_dp_cur    = 1'b0;
    w_blank_cur = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (r_digit_idx == 3'(i)) begin
        w_nibble    = r_active.digits[4*i +: 4];
        w_dp_cur    = r_active.dp[i];
        w_blank_cur = r_active.blank[i] | w_suppress[i];
      end
    end
  end

  assign w_font = font(w_nibble);
  // Slot count 0 stays dark so the previous digit never ghosts onto the next anode.
  assign w_on   = display_en && (r_slot_cnt != '0) && (r_pwm_cnt <= brightness);

  always_comb begin
    w_cathodes = 8'hFF;
    w_anodes   = 8'hFF;
    if (w_on) begin
      w_cathodes = {(w_blank_cur ? 7'h7F : w_font[7:1]), ~w_dp_cur};
      w_anodes   = ~(8'd1 << r_digit_idx);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_slot_cnt   <= '0;
      r_digit_idx  <= '0;
      r_pwm_cnt    <= '0;
      r_pend_valid <= 1'b0;
      r_pending    <= DISP_RESET;
      r_active     <= DISP_RESET;
      r_cathodes   <= 8'hFF;
      r_anodes     <= 8'hFF;
      r_scan_idx   <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_slot_cnt <= w_slot_wrap ? '0 : r_slot_cnt + 1'b1;
      r_pwm_cnt  <= w_slot_wrap ? '0 : r_pwm_cnt + 1'b1;
      if (w_slot_wrap)
        r_digit_idx <= w_frame_wrap ? 3'd0 : r_digit_idx + 3'd1;

      // A load on the wrap cycle stays pending; the older pending data goes active.
      if (w_frame_wrap && r_pend_valid)
        r_active <= r_pending;
      if (load) begin
        r_pending    <= w_load_data;
        r_pend_valid <= 1'b1;
      end else if (w_frame_wrap) begin
        r_pend_valid <= 1'b0;
      end

      r_cathodes   <= w_cathodes;
      r_anodes     <= w_anodes;
      r_scan_idx   <= r_digit_idx;
      r_frame_tick <= w_frame_wrap;
    end
  end

  assign ssd_cathodes = r_cathodes;
  assign anodes       = r_anodes;
  assign scan_idx     = r_scan_idx;
  assign frame_tick   = r_frame_tick;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Scoreboard bench for ssd_scan_driver: an arithmetic reference model predicts each
// registered output cycle, and a separate monitor pops and compares.
module tb_ssd_scan_driver;

  localparam int N     = 3;
  localparam int SLOT  = 6;
  localparam int PB    = 2;
  localparam int DW    = 4 * N;
  localparam int FRAME = SLOT * N;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] digits_in = '0;
  logic [N-1:0]  dp_in = '0;
  logic [N-1:0]  blank_in = '0;
  logic          lz_en = 1'b0;
  logic          load = 1'b0;
  logic [PB-1:0] brightness = '1;
  logic          display_en = 1'b1;
  logic [7:0]    ssd_cathodes;
  logic [7:0]    anodes;
  logic [2:0]    scan_idx;
  logic          frame_tick;

  ssd_scan_driver #(.N_DIGITS(N), .SLOT_CYCLES(SLOT), .PWM_BITS(PB)) dut (
    .clk(clk), .reset(reset), .digits_in(digits_in), .dp_in(dp_in),
    .blank_in(blank_in), .lz_en(lz_en), .load(load), .brightness(brightness),
    .display_en(display_en), .ssd_cathodes(ssd_cathodes), .anodes(anodes),
    .scan_idx(scan_idx), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] digits;
    logic [N-1:0]  dp;
    logic [N-1:0]  blank;
    logic          lz;
  } disp_t;

  typedef struct packed {
    logic [7:0] cath;
    logic [7:0] an;
    logic [2:0] idx;
    logic       tick;
  } exp_t;

  logic [7:0] font_tbl [16];
  disp_t      m_pend, m_act;
  bit         m_pvalid;
  int         m_t;
  exp_t       q[$];
  int         total = 0;
  int         bad = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_t      = 0;
    m_pvalid = 0;
    m_pend   = '{digits: '0, dp: '0, blank: '1, lz: 1'b0};
    m_act    = m_pend;
  endtask

  // Predict the outputs the next clock edge will register, advance the model, then
  // wait for the falling edge where the caller drives the next inputs.
  task automatic cyc();
    exp_t          e;
    int            slot, idx, pwm, hi;
    logic [DW-1:0] sh;
    logic [3:0]    nib;
    logic [7:0]    glyph;
    logic          on, sup;
    logic [6:0]    segs;
    if (reset) begin
      e.cath = 8'hFF; e.an = 8'hFF; e.idx = 3'd0; e.tick = 1'b0;
      model_reset();
    end else begin
      slot = m_t % SLOT;
      idx  = (m_t / SLOT) % N;
      pwm  = slot % (1 << PB);
      on   = display_en && (slot != 0) && (pwm <= int'(brightness));
      sh   = m_act.digits >> (4 * idx);
      nib  = sh[3:0];
      hi   = 0;
      for (int i = 0; i < N; i++) begin
        sh = m_act.digits >> (4 * i);
        if (sh[3:0] != 4'h0) hi = i;
      end
      sup   = m_act.lz && (idx > hi);
      glyph = font_tbl[nib];
      segs  = (m_act.blank[idx] || sup) ? 7'h7F : glyph[7:1];
      e.cath = on ? {segs, ~m_act.dp[idx]} : 8'hFF;
      e.an   = 8'hFF;
      if (on) e.an[idx] = 1'b0;
      e.idx  = 3'(idx);
      e.tick = ((m_t % FRAME) == FRAME - 1);
      if (e.tick && m_pvalid) begin
        m_act    = m_pend;
        m_pvalid = 0;
      end
      if (load) begin
        m_pend   = '{digits: digits_in, dp: dp_in, blank: blank_in, lz: lz_en};
        m_pvalid = 1;
      end
      m_t++;
    end
    q.push_back(e);
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_load(input logic [DW-1:0] dg, input logic [N-1:0] dpv,
                         input logic [N-1:0] blk, input logic lz);
    digits_in = dg; dp_in = dpv; blank_in = blk; lz_en = lz; load = 1'b1;
    cyc();
  endtask

  task automatic to_wrap();
    while ((m_t % FRAME) != FRAME - 1) cyc();
  endtask

  // Monitor: outputs are valid every cycle, sampled just after the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("anodes", anodes, e.an);
        check("cathodes", ssd_cathodes, e.cath);
        check("scan_idx", {5'd0, scan_idx}, {5'd0, e.idx});
        check("frame_tick", {7'd0, frame_tick}, {7'd0, e.tick});
      end
    end
  end

  initial begin
    font_tbl = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                 8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    run(2);
    reset = 1'b0;
    brightness = 2'd3;
    run(FRAME + 3);

    do_load(12'h123, 3'b010, 3'b000, 1'b0);
    run(2 * FRAME);

    to_wrap(); run(2);
    do_load(12'h111, 3'b000, 3'b000, 1'b0);
    run(4);
    do_load(12'h222, 3'b001, 3'b000, 1'b0);
    run(2 * FRAME);

    do_load(12'h040, 3'b000, 3'b000, 1'b1);
    run(2 * FRAME);
    do_load(12'h000, 3'b100, 3'b000, 1'b1);
    run(2 * FRAME);

    do_load(12'hABC, 3'b000, 3'b010, 1'b0);
    to_wrap();
    do_load(12'hDEF, 3'b111, 3'b000, 1'b0);
    run(2 * FRAME);

    brightness = 2'd0;
    run(FRAME);
    brightness = 2'd1;
    run(FRAME);
    display_en = 1'b0;
    run(FRAME);
    display_en = 1'b1;
    brightness = 2'd3;

    do_load(12'h777, 3'b000, 3'b000, 1'b0);
    run(3);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    run(2 * FRAME);

    for (int k = 0; k < 700; k++) begin
      if ($urandom_range(0, 15) == 0) brightness = PB'($urandom);
      if ($urandom_range(0, 31) == 0) display_en = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 7) == 0) begin
        digits_in = DW'($urandom);
        if ($urandom_range(0, 1) == 1) digits_in = digits_in >> (4 * $urandom_range(1, N - 1));
        dp_in    = N'($urandom);
        blank_in = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
        lz_en    = 1'($urandom_range(0, 1));
        load     = 1'b1;
      end
      cyc();
      reset = 1'b0;
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expected outputs never compared, required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
